// File: rtl/sao_deci_seq_if.sv
// Handshake and status bundle between the SAO decision sequencer and its
// statistics source, decision datapath and parameter writer.
interface sao_deci_seq_if #(
  parameter int unsigned CTB_ADDR_W = 7
);
  logic                  start;
  logic                  flush;
  logic [CTB_ADDR_W-1:0] ctb_x;
  logic [CTB_ADDR_W-1:0] ctb_y;
  logic                  left_bnd;
  logic                  up_bnd;
  logic                  stat_vld;
  logic                  stall;
  logic                  stat_ack;
  logic [5:0]            cnt;
  logic [1:0]            cIdx;
  logic                  en_o;
  logic                  isWorking_deci;
  logic                  isLeftMergeAvail;
  logic                  isUpperMergeAvail;
  logic                  busy;
  logic                  done;

  modport master (
    output start, flush, ctb_x, ctb_y, left_bnd, up_bnd, stat_vld, stall,
    input  stat_ack, cnt, cIdx, en_o, isWorking_deci, isLeftMergeAvail,
           isUpperMergeAvail, busy, done
  );

  modport slave (
    input  start, flush, ctb_x, ctb_y, left_bnd, up_bnd, stat_vld, stall,
    output stat_ack, cnt, cIdx, en_o, isWorking_deci, isLeftMergeAvail,
           isUpperMergeAvail, busy, done
  );
endinterface

// File: rtl/sao_deci_seq.sv
// Per-CTB SAO decision sequencer: walks cIdx 0..2, and for each component waits
// for statistics then sweeps the phase counter 0..CNT_LAST.
module sao_deci_seq #(
  parameter int unsigned CNT_LAST = 35
) (
  input logic           clk,
  input logic           arst,
  sao_deci_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT_STAT, RUN, DONE} state_t;

  state_t     state, state_nxt;
  logic [5:0] cnt;
  logic [1:0] cidx;
  logic       left_ok, up_ok, busy_q, done_q, working_q;
  logic       at_last;

  assign at_last = (cnt == 6'(CNT_LAST));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:      if (bus.start)    state_nxt = WAIT_STAT;
        WAIT_STAT: if (bus.stat_vld) state_nxt = RUN;
        RUN:       if (!bus.stall && at_last)
                     state_nxt = (cidx == 2'd2) ? DONE : WAIT_STAT;
        DONE:      state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.en_o     = (state == RUN) && !bus.stall && !bus.flush;
    bus.stat_ack = (state == WAIT_STAT) && bus.stat_vld && !bus.flush;
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt       <= '0;
      cidx      <= '0;
      left_ok   <= 1'b0;
      up_ok     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      working_q <= 1'b0;
    end else begin
      busy_q    <= (state_nxt != IDLE);
      done_q    <= (state_nxt == DONE);
      working_q <= (state_nxt == RUN);
      if (bus.flush) begin
        cnt     <= '0;
        cidx    <= '0;
        left_ok <= 1'b0;
        up_ok   <= 1'b0;
      end else begin
        case (state)
          IDLE: if (bus.start) begin
            cnt     <= '0;
            cidx    <= '0;
            left_ok <= (bus.ctb_x != '0) && !bus.left_bnd;
            up_ok   <= (bus.ctb_y != '0) && !bus.up_bnd;
          end
          RUN: if (!bus.stall) begin
            if (at_last) begin
              if (cidx != 2'd2) begin
                cidx <= cidx + 2'd1;
                cnt  <= '0;
              end
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
          DONE: begin
            cnt  <= '0;
            cidx <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.cnt               = cnt;
  assign bus.cIdx              = cidx;
  assign bus.isLeftMergeAvail  = left_ok;
  assign bus.isUpperMergeAvail = up_ok;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.isWorking_deci    = working_q;

endmodule

// File: tb/tb_sao_deci_seq.sv
// Testbench for sao_deci_seq: directed CTB scenarios plus random traffic, checked
// against a progress-counter model of the per-CTB schedule.
module tb_sao_deci_seq;
  localparam int CNT_LAST = 35;
  localparam int L        = CNT_LAST + 2;  // one wait slot plus CNT_LAST+1 run slots
  localparam int END      = 3 * L;         // progress value of the done cycle

  logic clk  = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  sao_deci_seq_if #(.CTB_ADDR_W(7)) bus();
  sao_deci_seq #(.CNT_LAST(CNT_LAST)) dut (.clk(clk), .arst(arst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  int en_cnt = 0;

  // Model: idle, or busy at progress position m_pos within the CTB schedule.
  bit m_busy = 1'b0;
  int m_pos  = 0;
  bit m_lf   = 1'b0;
  bit m_uf   = 1'b0;

  function automatic bit e_run();
    return m_busy && m_pos < END && (m_pos % L) != 0;
  endfunction
  function automatic bit e_wait();
    return m_busy && m_pos < END && (m_pos % L) == 0;
  endfunction
  function automatic int e_cnt();
    if (!m_busy) return 0;
    if (m_pos == END) return CNT_LAST;
    return ((m_pos % L) == 0) ? 0 : (m_pos % L) - 1;
  endfunction
  function automatic int e_cidx();
    if (!m_busy) return 0;
    if (m_pos == END) return 2;
    return m_pos / L;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_regs();
    chk("busy", bus.busy, m_busy);
    chk("done", bus.done, m_busy && m_pos == END);
    chk("isWorking_deci", bus.isWorking_deci, e_run());
    chk("cnt", bus.cnt, e_cnt());
    chk("cIdx", bus.cIdx, e_cidx());
    chk("isLeftMergeAvail", bus.isLeftMergeAvail, m_lf);
    chk("isUpperMergeAvail", bus.isUpperMergeAvail, m_uf);
  endtask

  task automatic step(input bit st, input bit fl, input bit sv, input bit sl);
    @(negedge clk);
    bus.start = st; bus.flush = fl; bus.stat_vld = sv; bus.stall = sl;
    #1;
    chk("en_o", bus.en_o, e_run() && !sl && !fl);
    chk("stat_ack", bus.stat_ack, e_wait() && sv && !fl);
    if (bus.en_o === 1'b1) en_cnt++;
    @(posedge clk);
    if (fl) begin
      m_busy = 1'b0; m_lf = 1'b0; m_uf = 1'b0;
    end else if (!m_busy) begin
      if (st) begin
        m_busy = 1'b1; m_pos = 0;
        m_lf = (bus.ctb_x != 0) && !bus.left_bnd;
        m_uf = (bus.ctb_y != 0) && !bus.up_bnd;
      end
    end else if (m_pos == END) begin
      m_busy = 1'b0;
    end else if ((m_pos % L) == 0) begin
      if (sv) m_pos++;
    end else if (!sl) begin
      m_pos++;
    end
    #1;
    chk_regs();
  endtask

  // One full CTB from a start in relative cycle 0; optional stall / stat_vld gap.
  task automatic ctb(input int x, input int y, input bit lb, input bit ub,
                     input int stall_c, input int stall_n, input int stall_len,
                     input int wait_c, input int wait_len, input bit extra,
                     input int exp_lat);
    int rel = 0;
    int lat = -1;
    bit seen = 1'b0;
    int sl_left = stall_len;
    int w_left = wait_len;
    bit sv, sl, st;
    bus.ctb_x = 7'(x); bus.ctb_y = 7'(y); bus.left_bnd = lb; bus.up_bnd = ub;
    en_cnt = 0;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    rel = 1;
    while (!seen && rel < 400) begin
      sv = 1'b1; sl = 1'b0;
      if (e_run() && e_cidx() == stall_c && e_cnt() == stall_n && sl_left > 0) begin
        sl = 1'b1; sl_left--;
      end
      if (e_wait() && e_cidx() == wait_c && w_left > 0) begin
        sv = 1'b0; sl = 1'b1; w_left--;
      end
      st = extra && rel == 50;
      step(st, 1'b0, sv, sl);
      rel++;
      if (bus.done === 1'b1) begin
        seen = 1'b1; lat = rel;
      end
    end
    chk("done_latency", lat, exp_lat);
    chk("en_o_cycles", en_cnt, 108);
    step(extra, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0; bus.flush = 1'b0; bus.stat_vld = 1'b0; bus.stall = 1'b0;
    bus.ctb_x = '0; bus.ctb_y = '0; bus.left_bnd = 1'b0; bus.up_bnd = 1'b0;
    #2;
    chk_regs();
    chk("reset_en_o", bus.en_o, 0);
    chk("reset_stat_ack", bus.stat_ack, 0);
    @(negedge clk);
    arst = 1'b0;

    // Reference run
    ctb(3, 0, 0, 0, -1, 0, 0, -1, 0, 1'b0, 112);
    // Stall at cIdx 1, cnt 20 for 5 cycles
    ctb(5, 2, 0, 0, 1, 20, 5, -1, 0, 1'b0, 117);
    // stat_vld low for 10 cycles entering cIdx 2
    ctb(1, 1, 1, 0, -1, 0, 0, 2, 10, 1'b0, 122);

    // Flush at cIdx 0, cnt 10
    bus.ctb_x = 7'd9; bus.ctb_y = 7'd4; bus.left_bnd = 1'b0; bus.up_bnd = 1'b0;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int g = 0; g < 60 && !(e_run() && e_cidx() == 0 && e_cnt() == 10); g++)
      step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("pre_flush_cnt", bus.cnt, 10);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("flush_busy", bus.busy, 0);
    chk("flush_left", bus.isLeftMergeAvail, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("flush_no_done", bus.done, 0);
    ctb(0, 5, 0, 1, -1, 0, 0, -1, 0, 1'b0, 112);

    // Starts at cycles 50 and 112 ignored, then a start in cycle 113 accepted
    ctb(2, 3, 0, 0, -1, 0, 0, -1, 0, 1'b1, 112);
    ctb(4, 6, 0, 0, -1, 0, 0, -1, 0, 1'b0, 112);

    // Asynchronous reset mid-run
    bus.ctb_x = 7'd7; bus.ctb_y = 7'd7;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 60; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    arst = 1'b1;
    #1;
    m_busy = 1'b0; m_pos = 0; m_lf = 1'b0; m_uf = 1'b0;
    chk_regs();
    chk("arst_en_o", bus.en_o, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk_regs();
    end
    @(negedge clk);
    arst = 1'b0;
    ctb(6, 1, 0, 0, -1, 0, 0, -1, 0, 1'b0, 112);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      bus.ctb_x    = 7'($urandom_range(0, 3));
      bus.ctb_y    = 7'($urandom_range(0, 3));
      bus.left_bnd = ($urandom_range(0, 3) == 0);
      bus.up_bnd   = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sao_deci_seq.md
# sao_deci_seq

Per-CTB sequencer for the SAO rate-distortion decision stage. It accepts a CTB start, then steps the decision datapath through luma, Cb and Cr (cIdx 0→1→2). For each component it waits for that component's statistics, then drives the phase counter `cnt` from 0 to CNT_LAST, one step per enabled cycle. It also generates the decision-enable/working strobes, the left/upper merge-availability flags and a completion pulse for the SAO parameter writer.

## Interface
- CNT_LAST, 35: last phase value per component (cost datapath clears at 32 and resets its bests at 35).
- CTB_ADDR_W, 7: width of CTB x/y address.
- clk  in  1  clock.
- arst  in  1  asynchronous reset, active-high.
- start  in  1  CTB decision request; sampled only in IDLE.
- flush  in  1  synchronous abort; returns to IDLE next cycle, no done.
- ctb_x  in  CTB_ADDR_W  CTB column; latched on accepted start.
- ctb_y  in  CTB_ADDR_W  CTB row; latched on accepted start.
- left_bnd  in  1  left neighbour is in another slice/tile; latched on start.
- up_bnd  in  1  upper neighbour is in another slice/tile; latched on start.
- stat_vld  in  1  statistics for current cIdx are available.
- stall  in  1  downstream hold; freezes cnt.
- stat_ack  out  1  one-cycle pulse when statistics for current cIdx are consumed.
- cnt  out  6  decision phase counter.
- cIdx  out  2  current component: 0 Y, 1 Cb, 2 Cr.
- en_o  out  1  decision datapath enable.
- isWorking_deci  out  1  high throughout RUN, including stalled cycles.
- isLeftMergeAvail  out  1  left-merge candidate legal.
- isUpperMergeAvail  out  1  upper-merge candidate legal.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse when decision outputs are final.

## Operation
- States: IDLE, WAIT_STAT, RUN, DONE.
- IDLE:
  - start=1 → WAIT_STAT, cIdx=0, cnt=0.
  - Latch isLeftMergeAvail = (ctb_x≠0)&&!left_bnd.
  - Latch isUpperMergeAvail = (ctb_y≠0)&&!up_bnd.
- WAIT_STAT: cnt held at 0, en_o=0.
  - stat_vld=1 → RUN, with stat_ack=1 in that same cycle.
- RUN: en_o = !stall, so en_o falls in the same cycle stall rises.
  - stall=0: cnt increments each cycle.
  - stall=1: cnt, cIdx and state frozen.
- RUN at cnt==CNT_LAST with stall=0:
  - cIdx<2 → cIdx+1, cnt=0, WAIT_STAT.
  - cIdx==2 → DONE; cnt and cIdx keep their values.
- DONE: done=1 for one cycle → IDLE; cnt and cIdx return to 0 on entering IDLE.
- start while busy: ignored, not queued.
- flush: overrides every other input in any state.
  - Next cycle: IDLE, cnt=0, cIdx=0, en_o=0.
  - done does not assert; merge flags are cleared.
- Merge flags hold from start until the next accepted start, flush or arst.
- cnt never exceeds CNT_LAST. cIdx never reaches 3.
- Reset values (arst=1): state IDLE, all outputs 0.

## Timing
- All outputs are registered except en_o and stat_ack, which are combinational from state/stall/stat_vld.
- Reference run, with stat_vld held high and stall=0, start high in cycle 0:
  - cycle 1: WAIT_STAT, cIdx 0.
  - cycles 2–37: RUN, cnt 0..35.
  - cycle 38: WAIT_STAT, cIdx 1.
  - cycles 39–74: RUN.
  - cycle 75: WAIT_STAT, cIdx 2.
  - cycles 76–111: RUN.
  - cycle 112: done=1.
  - cycle 113: IDLE, ready for the next start.
- Minimum CTB latency: 3·(CNT_LAST+2)+2 = 113 cycles.
- Each stalled cycle adds exactly one cycle.
- Each WAIT_STAT cycle with stat_vld=0 adds one cycle.
- stall during WAIT_STAT has no effect.
- stall at cnt==CNT_LAST delays the component advance until stall drops.
- arst asserted mid-run forces IDLE asynchronously. After release, the next start begins a fresh CTB.

## Test plan
- Reference run: start in cycle 0, stat_vld=1, stall=0, ctb_x=3, ctb_y=0, bnd=0.
  - done at cycle 112.
  - isLeftMergeAvail=1, isUpperMergeAvail=0.
  - cnt sequence 0..35 three times with cIdx 0,1,2.
  - en_o high for exactly 108 cycles.
- Stall at cIdx=1, cnt=20, held 5 cycles.
  - cnt stays 20 and en_o=0 for those 5 cycles; isWorking_deci stays 1.
  - done at cycle 117.
- stat_vld low for 10 cycles at entry to cIdx 2.
  - cnt=0 and en_o=0 throughout the wait; stat_ack pulses once when stat_vld rises.
  - done at cycle 122.
- flush at cIdx=0, cnt=10.
  - Next cycle IDLE, all outputs 0, no done pulse.
  - A new start at ctb_x=0, ctb_y=5, up_bnd=1 gives both merge flags 0 and done 112 cycles later.
- start pulsed at cycles 50 and 112 during a run.
  - Only one done (cycle 112); both extra starts are ignored.
  - A start in cycle 113 is accepted.
- arst asserted at cycle 60, released at 62.
  - All outputs 0 from assertion onward.
  - A subsequent start completes in 113 cycles.
